// File: rtl/axil_req_arbiter_if.sv
// Purpose : bundle of requester-side and master-side signals around axil_req_arbiter.
// Latency : n/a (wires only).
// Backpressure: req_valid/req_ready per requester; responses have no backpressure.
// Ports:
//   requester side : req_valid, req_ready, req_op, req_addr, req_wdata (packed per requester),
//                    resp_valid (one-hot), resp_rdata, resp_err
//   master side    : m_addr, m_wdata, m_opcode (to master); m_rdata, m_rvalid, m_wdone,
//                    m_rd_err, m_wr_err, m_busy (from master)
//   modport slave  : the arbiter's view; modport master : the requesters' + master's view.
interface axil_req_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 32
) ();
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [2*NUM_REQ-1:0]        req_op;
  logic [ADDR_LEN*NUM_REQ-1:0] req_addr;
  logic [DATA_LEN*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]          resp_valid;
  logic [DATA_LEN-1:0]         resp_rdata;
  logic                        resp_err;

  logic [ADDR_LEN-1:0]         m_addr;
  logic [DATA_LEN-1:0]         m_wdata;
  logic [1:0]                  m_opcode;
  logic [DATA_LEN-1:0]         m_rdata;
  logic                        m_rvalid;
  logic                        m_wdone;
  logic                        m_rd_err;
  logic                        m_wr_err;
  logic                        m_busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  m_rdata, m_rvalid, m_wdone, m_rd_err, m_wr_err, m_busy,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_addr, m_wdata, m_opcode
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output m_rdata, m_rvalid, m_wdone, m_rd_err, m_wr_err, m_busy,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_addr, m_wdata, m_opcode
  );
endinterface

// File: rtl/axil_req_arbiter.sv
// Purpose : round-robin share of one easy_axilite_master user port among NUM_REQ requesters.
// Latency : accept c0, opcode c1 (later if m_busy), response 1 cycle after completion; illegal op responds at c1.
// Backpressure: one request in flight; req_ready only in IDLE; m_busy stalls ISSUE; responses cannot be stalled.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (the master shares this reset)
//   bus       : axil_req_arbiter_if.slave (requester request/response + master user port)
module axil_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  axil_req_arbiter_if.slave bus
);

  localparam int         IDX_W = $clog2(NUM_REQ);
  localparam logic [1:0] OP_WR = 2'd1;
  localparam logic [1:0] OP_RD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [1:0]          op_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic                err_q;

  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand;
  logic                gnt_found;
  logic                accept;
  logic                op_legal;
  logic                issue;
  logic                cpl;

  // Per-requester views of the packed request buses.
  logic [1:0]          op_arr    [NUM_REQ];
  logic [ADDR_LEN-1:0] addr_arr  [NUM_REQ];
  logic [DATA_LEN-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]    = bus.req_op[2*g +: 2];
    assign addr_arr[g]  = bus.req_addr[ADDR_LEN*g +: ADDR_LEN];
    assign wdata_arr[g] = bus.req_wdata[DATA_LEN*g +: DATA_LEN];
  end

  // Round-robin search: first valid requester after ptr, wrapping around.
  // The last candidate examined is ptr itself, so a lone requester can win back-to-back.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // No handshake while reset is held: anything accepted then would be wiped anyway.
  assign accept   = (state_q == S_IDLE) && gnt_found && !rst;
  assign op_legal = (op_arr[gnt_idx] == OP_WR) || (op_arr[gnt_idx] == OP_RD);
  assign issue    = (state_q == S_ISSUE) && !bus.m_busy && !rst;
  // Only the completion matching the in-flight op counts; a stray pulse of the other kind is ignored.
  assign cpl      = (state_q == S_WAIT) &&
                    (((op_q == OP_WR) && bus.m_wdone) || ((op_q == OP_RD) && bus.m_rvalid));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = op_legal ? S_ISSUE : S_RESP;
      S_ISSUE: if (issue)  state_d = S_WAIT;
      S_WAIT:  if (cpl)    state_d = S_RESP;
      S_RESP:              state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  // Captured request, result and fairness pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= gnt_idx;
        op_q    <= op_arr[gnt_idx];
        rdata_q <= '0;
        // An illegal opcode is answered with an error without touching the master.
        err_q   <= !op_legal;
        if (op_legal) begin
          addr_q  <= addr_arr[gnt_idx];
          wdata_q <= wdata_arr[gnt_idx];
        end
      end
      if (cpl) begin
        if (op_q == OP_RD) begin
          rdata_q <= bus.m_rdata;
          err_q   <= bus.m_rd_err;
        end else begin
          err_q   <= bus.m_wr_err;
        end
      end
      if (state_q == S_RESP) begin
        ptr_q <= idx_q;
      end
    end
  end

  // Output logic
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_err   = 1'b0;
    bus.m_opcode   = 2'd0;
    if (accept) begin
      bus.req_ready = NUM_REQ'(1) << gnt_idx;
    end
    if (state_q == S_RESP) begin
      bus.resp_valid = NUM_REQ'(1) << idx_q;
      bus.resp_err   = err_q;
    end
    // Opcode is a single-cycle trigger; holding it at 0 elsewhere keeps the master from re-firing.
    if (issue) begin
      bus.m_opcode = op_q;
    end
  end

  assign bus.m_addr     = addr_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.resp_rdata = rdata_q;

endmodule
